// File: rtl/spi_master.sv
// SPI command master: shifts a 10-bit opcode+payload word out MSB first and,
// for read-data frames, waits WAIT_CYCLES idle cycles before clocking in one byte.
module spi_master #(
  parameter int unsigned WAIT_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [9:0] cmd_word,
  output logic       SS_n,
  output logic       MOSI,
  input  logic       MISO,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       busy
);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_SHIFT = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RECV  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);

  state_t      state_r;
  logic [9:0]  cmd_r;
  logic [3:0]  bit_cnt_r;
  logic [3:0]  wait_cnt_r;
  logic [6:0]  rx_sh_r;
  logic [7:0]  rd_data_r;
  logic        rd_valid_r;
  logic        ss_n_r;
  logic        mosi_r;
  logic        cmd_ready_r;

  assign cmd_ready = cmd_ready_r;
  assign busy      = ~cmd_ready_r;
  assign SS_n      = ss_n_r;
  assign MOSI      = mosi_r;
  assign rd_data   = rd_data_r;
  assign rd_valid  = rd_valid_r;

  // Frame sequencer; every output is loaded with the value of the state being entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      cmd_r       <= 10'd0;
      bit_cnt_r   <= 4'd0;
      wait_cnt_r  <= 4'd0;
      rx_sh_r     <= 7'd0;
      rd_data_r   <= 8'h00;
      rd_valid_r  <= 1'b0;
      ss_n_r      <= 1'b1;
      mosi_r      <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      rd_valid_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_r       <= cmd_word;
            state_r     <= ST_START;
            ss_n_r      <= 1'b0;
            mosi_r      <= cmd_word[9];
            cmd_ready_r <= 1'b0;
          end
        end
        ST_START: begin
          state_r   <= ST_SHIFT;
          bit_cnt_r <= 4'd0;
          mosi_r    <= cmd_r[9];
        end
        ST_SHIFT: begin
          if (bit_cnt_r == 4'd9) begin
            bit_cnt_r <= 4'd0;
            mosi_r    <= 1'b0;
            if (cmd_r[9:8] == 2'b11) begin
              state_r    <= ST_WAIT;
              wait_cnt_r <= 4'd0;
            end else begin
              state_r <= ST_GAP;
              ss_n_r  <= 1'b1;
            end
          end else begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
            mosi_r    <= cmd_r[4'd8 - bit_cnt_r];
          end
        end
        ST_WAIT: begin
          if (wait_cnt_r == WAIT_LAST) begin
            state_r    <= ST_RECV;
            wait_cnt_r <= 4'd0;
            bit_cnt_r  <= 4'd0;
          end else begin
            wait_cnt_r <= wait_cnt_r + 4'd1;
          end
        end
        ST_RECV: begin
          // MISO is taken on the edge that closes each RECV cycle.
          rx_sh_r <= {rx_sh_r[5:0], MISO};
          if (bit_cnt_r == 4'd7) begin
            rd_data_r  <= {rx_sh_r, MISO};
            rd_valid_r <= 1'b1;
            bit_cnt_r  <= 4'd0;
            state_r    <= ST_GAP;
            ss_n_r     <= 1'b1;
          end else begin
            bit_cnt_r <= bit_cnt_r + 4'd1;
          end
        end
        ST_GAP: begin
          state_r     <= ST_IDLE;
          cmd_ready_r <= 1'b1;
        end
        default: begin
          state_r     <= ST_IDLE;
          bit_cnt_r   <= 4'd0;
          wait_cnt_r  <= 4'd0;
          ss_n_r      <= 1'b1;
          mosi_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_master.sv
// Directed bench for spi_master with a behavioural SPI slave + byte RAM and a
// scoreboard of expected frames and read bytes.
module tb_spi_master;

  localparam int W = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [9:0] cmd_word = 10'd0;
  logic       SS_n;
  logic       MOSI;
  logic       MISO = 1'b1;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       busy;

  always #5 clk = ~clk;

  spi_master #(.WAIT_CYCLES(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_word  (cmd_word),
    .SS_n      (SS_n),
    .MOSI      (MOSI),
    .MISO      (MISO),
    .rd_data   (rd_data),
    .rd_valid  (rd_valid),
    .busy      (busy)
  );

  typedef struct {
    logic [9:0] cmd;
    int         len;
  } frame_t;

  frame_t     fq[$];
  frame_t     cur;
  logic [7:0] sb[$];
  int         checks = 0;
  int         errors = 0;
  int         low_cnt = 0;
  int         hi_run = 100;
  int         last_gap = 0;
  logic [10:0] cap = 11'd0;

  logic [7:0] mem [0:255];
  int         s_idx = 0;
  logic [9:0] s_bits = 10'd0;
  logic [7:0] s_addr = 8'h00;
  logic [7:0] s_byte = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input logic [9:0] w, input logic [7:0] d);
    frame_t f;
    f.cmd = w;
    f.len = (w[9:8] == 2'b11) ? 19 + W : 11;
    fq.push_back(f);
    if (w[9:8] == 2'b11) sb.push_back(d);
  endtask

  task automatic send(input logic [9:0] w, input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (cmd_ready !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("send_ready", {31'd0, cmd_ready}, 32'd1);
    expect_frame(w, d);
    cmd_valid = 1'b1;
    cmd_word  = w;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_word  = 10'($urandom);
  endtask

  task automatic wait_ss(input logic lvl, input string tag);
    int n = 0;
    while (SS_n !== lvl && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, SS_n}, {31'd0, lvl});
  endtask

  // Slave: opcode 00/10 set the address, 01 writes RAM, 11 returns RAM[addr] during RECV.
  always @(negedge clk) begin
    if (!rst_n) begin
      s_idx = 0;
      MISO  = 1'b1;
    end else if (SS_n === 1'b0) begin
      if (s_idx >= 1 && s_idx <= 10) s_bits = {s_bits[8:0], MOSI};
      if (s_idx == 10) begin
        case (s_bits[9:8])
          2'b00:   s_addr = s_bits[7:0];
          2'b01:   mem[s_addr] = s_bits[7:0];
          2'b10:   s_addr = s_bits[7:0];
          default: s_byte = mem[s_addr];
        endcase
      end
      if (s_idx >= 11 + W && s_idx <= 18 + W) MISO = s_byte[18 + W - s_idx];
      else MISO = 1'b1;
      s_idx++;
    end else begin
      s_idx = 0;
      MISO  = 1'b1;
    end
  end

  // Monitor: frame length, MOSI stream, GAP behaviour and read-byte scoreboard.
  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt = 0;
      fq.delete();
      sb.delete();
    end else begin
      if (rd_valid === 1'b1) begin
        chk("rd_valid_in_gap", {31'd0, SS_n}, 32'd1);
        if (sb.size() == 0) chk("unexpected_rd_valid", 32'd1, 32'd0);
        else chk("rd_data", {24'd0, rd_data}, {24'd0, sb.pop_front()});
      end
      if (SS_n === 1'b0) begin
        if (low_cnt == 0) begin
          last_gap = hi_run;
          if (fq.size() == 0) chk("extra_frame", 32'd1, 32'd0);
          else cur = fq.pop_front();
        end
        if (low_cnt < 11) cap[10 - low_cnt] = MOSI;
        else chk("mosi_idle_tail", {31'd0, MOSI}, 32'd0);
        low_cnt++;
      end else if (low_cnt != 0) begin
        chk("ss_low_cycles", low_cnt, cur.len);
        chk("mosi_stream", {21'd0, cap}, {21'd0, cur.cmd[9], cur.cmd});
        chk("gap_ready_low", {31'd0, cmd_ready}, 32'd0);
        chk("gap_mosi", {31'd0, MOSI}, 32'd0);
        low_cnt = 0;
        hi_run  = 1;
      end else begin
        hi_run++;
      end
    end
  end

  logic [9:0] q3 [3];

  initial begin
    int n;
    for (int i = 0; i < 256; i++) mem[i] = 8'h00;
    // The write-address 0x0A5 frame below leaves the slave pointing at 0xA5.
    mem[8'hA5] = 8'h3C;

    repeat (3) @(negedge clk);
    chk("rst_ss_n", {31'd0, SS_n}, 32'd1);
    chk("rst_mosi", {31'd0, MOSI}, 32'd0);
    chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
    chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_ready", {31'd0, cmd_ready}, 32'd1);

    // Write-address 0x0A5
    send(10'h0A5, 8'h00);
    chk("w_busy", {31'd0, busy}, 32'd1);
    wait_ss(1'b1, "w_ss_rise");
    chk("w_gap_ready", {31'd0, cmd_ready}, 32'd0);
    @(negedge clk);
    chk("w_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("w_idle_busy", {31'd0, busy}, 32'd0);
    chk("w_rd_data_kept", {24'd0, rd_data}, 32'd0);

    // Read-data returning 0x3C
    send(10'h300, 8'h3C);
    wait_ss(1'b1, "r_ss_rise");
    @(negedge clk);
    chk("r_rd_data", {24'd0, rd_data}, 32'h3C);
    chk("r_rd_valid_gone", {31'd0, rd_valid}, 32'd0);

    // Mid-frame cmd_valid/cmd_word noise must be ignored
    send(10'h033, 8'h00);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_word  = 10'($urandom);
    end
    cmd_valid = 1'b0;
    wait_ss(1'b1, "n_ss_rise");
    repeat (6) @(negedge clk);
    chk("n_no_extra_frame", {31'd0, SS_n}, 32'd1);
    chk("n_rd_data_hold", {24'd0, rd_data}, 32'h3C);

    // Reset during RECV of a read
    send(10'h3FF, 8'h00);
    repeat (16) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_ss_n", {31'd0, SS_n}, 32'd1);
    chk("ar_mosi", {31'd0, MOSI}, 32'd0);
    chk("ar_rd_valid", {31'd0, rd_valid}, 32'd0);
    chk("ar_rd_data", {24'd0, rd_data}, 32'd0);
    chk("ar_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("ar_busy", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("ar_release_ready", {31'd0, cmd_ready}, 32'd1);
    chk("ar_release_ss", {31'd0, SS_n}, 32'd1);
    repeat (25) @(negedge clk);
    chk("ar_rd_data_still0", {24'd0, rd_data}, 32'd0);

    // End-to-end through the slave RAM
    send(10'h010, 8'h00);
    send(10'h15A, 8'h00);
    send(10'h210, 8'h00);
    send(10'h300, 8'h5A);
    wait_ss(1'b1, "e2e_ss_rise");
    @(negedge clk);
    chk("e2e_rd_data", {24'd0, rd_data}, 32'h5A);

    // Three commands with cmd_valid held high
    q3[0] = 10'h020;
    q3[1] = 10'h177;
    q3[2] = 10'h300;
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_word  = q3[0];
    for (int i = 0; i < 3; i++) begin
      n = 0;
      while (cmd_ready !== 1'b1 && n < 100) begin
        @(negedge clk);
        n++;
      end
      chk("b2b_ready", {31'd0, cmd_ready}, 32'd1);
      expect_frame(q3[i], 8'h77);
      @(negedge clk);
      #1;
      chk("b2b_started", {31'd0, SS_n}, 32'd0);
      if (i > 0) chk("b2b_gap", last_gap, 32'd2);
      if (i < 2) cmd_word = q3[i + 1];
      else cmd_valid = 1'b0;
    end
    wait_ss(1'b1, "b2b_ss_rise");
    @(negedge clk);
    chk("b2b_rd_data", {24'd0, rd_data}, 32'h77);

    repeat (4) @(negedge clk);
    chk("frames_drained", fq.size(), 32'd0);
    chk("reads_drained", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
